// File: rtl/instr_encoder.sv
// instr_encoder: RV32I field-to-word encoder with a single output register and a word-address counter.
// Define ENC_STRICT_EN to add immediate range checks to outErr.
module instr_encoder #(
  parameter int ADDR_W             = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              inValid,
  output logic              inReady,
  input  logic [3:0]        inFmt,
  input  logic [4:0]        inRd,
  input  logic [4:0]        inRs1,
  input  logic [4:0]        inRs2,
  input  logic [2:0]        inFunct3,
  input  logic [6:0]        inFunct7,
  input  logic [31:0]       inImm,
  output logic              outValid,
  input  logic              outReady,
  output logic [31:0]       outInstr,
  output logic [ADDR_W-1:0] outAddr,
  output logic              outErr
);

  localparam logic [ADDR_W-1:0] L_BASE = ADDR_W'(BASE_ADDR);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [ADDR_W-1:0] r_cnt;

  logic [31:0]       w_instr;
  logic              w_fmtErr;
  logic              w_rangeErr;
  logic              w_isShift;
  logic              w_handshake;
  logic              w_accept;
  logic [ADDR_W-1:0] w_nextCnt;

  assign w_isShift = (inFunct3 == 3'b001) || (inFunct3 == 3'b101);

  always_comb begin
    w_instr  = 32'h0;
    w_fmtErr = 1'b0;
    case (inFmt)
      4'd0: w_instr = {inImm[31:12], inRd, OP_LUI};
      4'd1: w_instr = {inImm[31:12], inRd, OP_AUIPC};
      4'd2: w_instr = {inImm[20], inImm[10:1], inImm[11], inImm[19:12], inRd, OP_JAL};
      4'd3: w_instr = {inImm[11:0], inRs1, inFunct3, inRd, OP_JALR};
      4'd4: w_instr = {inImm[12], inImm[10:5], inRs2, inRs1, inFunct3,
                       inImm[4:1], inImm[11], OP_BRANCH};
      4'd5: w_instr = {inImm[11:0], inRs1, inFunct3, inRd, OP_LOAD};
      4'd6: w_instr = {inImm[11:5], inRs2, inRs1, inFunct3, inImm[4:0], OP_STORE};
      4'd7: begin
        if (w_isShift) w_instr = {inFunct7, inImm[4:0], inRs1, inFunct3, inRd, OP_ALUI};
        else           w_instr = {inImm[11:0], inRs1, inFunct3, inRd, OP_ALUI};
      end
      4'd8: w_instr = {inFunct7, inRs2, inRs1, inFunct3, inRd, OP_ALUR};
      default: w_fmtErr = 1'b1;
    endcase
  end

`ifdef ENC_STRICT_EN
  logic w_iOk;
  logic w_bOk;
  logic w_jOk;

  // An immediate fits in N signed bits when every bit from N-1 upward equals the sign.
  assign w_iOk = (&inImm[31:11]) | ~(|inImm[31:11]);
  assign w_bOk = (&inImm[31:12]) | ~(|inImm[31:12]);
  assign w_jOk = (&inImm[31:20]) | ~(|inImm[31:20]);

  always_comb begin
    w_rangeErr = 1'b0;
    case (inFmt)
      4'd0, 4'd1:       w_rangeErr = (inImm[11:0] != 12'h0);
      4'd2:             w_rangeErr = ~w_jOk | inImm[0];
      4'd3, 4'd5, 4'd6: w_rangeErr = ~w_iOk;
      4'd4:             w_rangeErr = ~w_bOk | inImm[0];
      4'd7:             w_rangeErr = w_isShift ? (inImm[31:5] != 27'h0) : ~w_iOk;
      default:          w_rangeErr = 1'b0;
    endcase
  end
`else
  assign w_rangeErr = 1'b0;
`endif

  assign w_handshake = r_valid & outReady;
  assign inReady     = ~restart & (~r_valid | outReady);
  assign w_accept    = inValid & inReady;
  assign w_nextCnt   = r_cnt + ADDR_W'(w_handshake);

  // A word loaded in the same cycle as a handshake takes the already-advanced address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= 32'h0;
      r_addr  <= L_BASE;
      r_err   <= 1'b0;
      r_cnt   <= L_BASE;
    end else if (restart) begin
      r_valid <= 1'b0;
      r_addr  <= L_BASE;
      r_cnt   <= L_BASE;
    end else begin
      r_cnt <= w_nextCnt;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_instr <= w_instr;
        r_err   <= w_fmtErr | w_rangeErr;
        r_addr  <= w_nextCnt;
      end else if (w_handshake) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign outValid = r_valid;
  assign outInstr = r_instr;
  assign outAddr  = r_addr;
  assign outErr   = r_err;

endmodule
